// File: rtl/k580vt57.sv
// K580VT57 (8257-compatible) four-channel DMA controller.
// CPU register file, bus hold handshake and S1-S4 transfer sequencing.
module k580vt57 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic [3:0]  iaddr,
  input  logic [7:0]  idata,
  output logic [7:0]  odata,
  input  logic        iwe_n,
  input  logic        ird_n,
  input  logic [3:0]  drq,
  output logic [3:0]  dack,
  output logic        hrq,
  input  logic        hlda,
  output logic [15:0] oaddr,
  output logic        omemr_n,
  output logic        omemw_n,
  output logic        oiord_n,
  output logic        oiowr_n,
  output logic        tc,
  output logic        mark,
  output logic        busy
);

  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 16;
  localparam int unsigned CW  = 14;

  typedef enum logic [2:0] {SI, S0, S1, S2, S3, S4} state_t;

  state_t          state_q, state_d;
  logic [1:0]      ch_q, ch_d, prio_q;
  logic [AW-1:0]   addr_q [NCH];
  logic [CW-1:0]   cnt_q  [NCH];
  logic [1:0]      mode_q [NCH];
  logic [NCH-1:0]  en_q, en_after;
  logic            rot_q, ext_q, tcstop_q, auto_q;
  logic [NCH-1:0]  tcflag_q;
  logic            update_q, ff_q, we_q, rd_q;

  logic            wr_rise, rd_rise, s4_fire, tc_hit, reload;
  logic [1:0]      sel_ch;
  logic [NCH-1:0]  req_idle, req_s4;
  logic [1:0]      win_idle, win_s4;
  logic [AW-1:0]   addr_s4, addr_sel;
  logic [CW-1:0]   cnt_s4, cnt_sel;
  logic [1:0]      mode_s4;
  logic            hrq_d, tc_d, mark_d, rd_act, wr_act;
  logic [3:0]      dack_d;
  logic [AW-1:0]   oaddr_d;

  // First requesting channel at or after base, wrapping around.
  function automatic logic [1:0] arbitrate(input logic [3:0] req, input logic [1:0] base);
    logic [1:0] win;
    logic [1:0] idx;
    logic       found;
    win   = base;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = base + 2'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign wr_rise  = iwe_n & ~we_q;
  assign rd_rise  = ird_n & ~rd_q;
  assign sel_ch   = iaddr[2:1];
  assign s4_fire  = ce && (state_q == S4);
  assign tc_hit   = (cnt_q[ch_q] == '0);
  assign reload   = tc_hit && (ch_q == 2'd2) && auto_q;
  assign addr_s4  = reload ? addr_q[3] : addr_q[ch_q] + 16'd1;
  assign cnt_s4   = reload ? cnt_q[3]  : cnt_q[ch_q] - 14'd1;
  assign mode_s4  = reload ? mode_q[3] : mode_q[ch_q];
  assign req_idle = drq & en_q;
  assign req_s4   = drq & en_after;
  assign win_idle = arbitrate(req_idle, rot_q ? prio_q : 2'd0);
  assign win_s4   = arbitrate(req_s4, rot_q ? ch_q + 2'd1 : 2'd0);

  // Enable mask as it will stand after the S4 bookkeeping.
  always_comb begin
    en_after = en_q;
    if (tc_hit && tcstop_q && !reload) en_after[ch_q] = 1'b0;
  end

  // Forward the post-S4 values when the same channel wins again.
  always_comb begin
    addr_sel = addr_q[ch_d];
    cnt_sel  = cnt_q[ch_d];
    if (state_q == S4 && ch_d == ch_q) begin
      addr_sel = addr_s4;
      cnt_sel  = cnt_s4;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    hrq_d   = hrq;
    dack_d  = '0;
    oaddr_d = oaddr;
    tc_d    = 1'b0;
    mark_d  = 1'b0;
    rd_act  = 1'b0;
    wr_act  = 1'b0;
    case (state_q)
      SI: if (|req_idle) begin
        state_d = S0;
        hrq_d   = 1'b1;
      end
      S0: if (hlda && |req_idle) begin
        state_d = S1;
        ch_d    = win_idle;
      end else if (!(|req_idle)) begin
        state_d = SI;
        hrq_d   = 1'b0;
      end
      S1: begin
        state_d = S2;
        dack_d  = dack;
        tc_d    = tc;
        mark_d  = mark;
        rd_act  = 1'b1;
        wr_act  = ext_q;
      end
      S2: begin
        state_d = S3;
        dack_d  = dack;
        tc_d    = tc;
        mark_d  = mark;
        rd_act  = 1'b1;
        wr_act  = 1'b1;
      end
      S3: state_d = S4;
      S4: if (hlda && |req_s4) begin
        state_d = S1;
        ch_d    = win_s4;
      end else begin
        state_d = SI;
        hrq_d   = 1'b0;
      end
      default: begin
        state_d = SI;
        hrq_d   = 1'b0;
      end
    endcase
    if (state_d == S1 && (state_q == S0 || state_q == S4)) begin
      dack_d  = 4'(1) << ch_d;
      oaddr_d = addr_sel;
      tc_d    = (cnt_sel == '0);
      mark_d  = (cnt_sel[6:0] == 7'd0);
    end
  end

  // Bus state and registered bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SI;
      ch_q    <= 2'd0;
      hrq     <= 1'b0;
      dack    <= '0;
      oaddr   <= '0;
      tc      <= 1'b0;
      mark    <= 1'b0;
      busy    <= 1'b0;
      omemr_n <= 1'b1;
      omemw_n <= 1'b1;
      oiord_n <= 1'b1;
      oiowr_n <= 1'b1;
    end else if (ce) begin
      state_q <= state_d;
      ch_q    <= ch_d;
      hrq     <= hrq_d;
      dack    <= dack_d;
      oaddr   <= oaddr_d;
      tc      <= tc_d;
      mark    <= mark_d;
      busy    <= (state_d != SI);
      omemr_n <= ~(rd_act && mode_q[ch_q] == 2'b10);
      oiord_n <= ~(rd_act && mode_q[ch_q] == 2'b01);
      omemw_n <= ~(wr_act && mode_q[ch_q] == 2'b01);
      oiowr_n <= ~(wr_act && mode_q[ch_q] == 2'b10);
    end
  end

  // Register file: read side effects, then S4 update, then CPU write (last wins).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NCH); i++) begin
        addr_q[i] <= '0;
        cnt_q[i]  <= '0;
        mode_q[i] <= '0;
      end
      en_q     <= '0;
      rot_q    <= 1'b0;
      ext_q    <= 1'b0;
      tcstop_q <= 1'b0;
      auto_q   <= 1'b0;
      tcflag_q <= '0;
      update_q <= 1'b0;
      ff_q     <= 1'b0;
      prio_q   <= 2'd0;
      we_q     <= 1'b1;
      rd_q     <= 1'b1;
    end else begin
      we_q <= iwe_n;
      rd_q <= ird_n;
      if (rd_rise) begin
        if (!iaddr[3]) ff_q <= ~ff_q;
        if (iaddr == 4'd8) begin
          tcflag_q <= '0;
          update_q <= 1'b0;
        end
      end
      if (s4_fire) begin
        addr_q[ch_q] <= addr_s4;
        cnt_q[ch_q]  <= cnt_s4;
        mode_q[ch_q] <= mode_s4;
        en_q         <= en_after;
        prio_q       <= ch_q + 2'd1;
        if (tc_hit) tcflag_q[ch_q] <= 1'b1;
        if (reload) update_q <= 1'b1;
      end
      if (wr_rise) begin
        if (!iaddr[3]) begin
          ff_q <= ~ff_q;
          if (!iaddr[0]) begin
            if (ff_q) addr_q[sel_ch][15:8] <= idata;
            else      addr_q[sel_ch][7:0]  <= idata;
            if (sel_ch == 2'd2 && auto_q) begin
              if (ff_q) addr_q[3][15:8] <= idata;
              else      addr_q[3][7:0]  <= idata;
            end
          end else begin
            if (ff_q) begin
              cnt_q[sel_ch][13:8] <= idata[5:0];
              mode_q[sel_ch]      <= idata[7:6];
            end else begin
              cnt_q[sel_ch][7:0]  <= idata;
            end
            if (sel_ch == 2'd2 && auto_q) begin
              if (ff_q) begin
                cnt_q[3][13:8] <= idata[5:0];
                mode_q[3]      <= idata[7:6];
              end else begin
                cnt_q[3][7:0]  <= idata;
              end
            end
          end
        end else if (iaddr == 4'd8) begin
          en_q     <= idata[3:0];
          rot_q    <= idata[4];
          ext_q    <= idata[5];
          tcstop_q <= idata[6];
          auto_q   <= idata[7];
          ff_q     <= 1'b0;
        end
      end
    end
  end

  // CPU read mux, byte chosen by the first/last flip-flop.
  always_comb begin
    odata = 8'h00;
    if (!iaddr[3]) begin
      if (!iaddr[0]) odata = ff_q ? addr_q[sel_ch][15:8] : addr_q[sel_ch][7:0];
      else           odata = ff_q ? {mode_q[sel_ch], cnt_q[sel_ch][13:8]} : cnt_q[sel_ch][7:0];
    end else if (iaddr == 4'd8) begin
      odata = {3'b000, update_q, tcflag_q};
    end
  end

endmodule

// File: tb/tb_k580vt57.sv
// Directed bench for k580vt57: register access table plus DMA transfer sequences.
module tb_k580vt57;

  logic        clk = 1'b0;
  logic        reset_n, ce, iwe_n, ird_n, hlda;
  logic [3:0]  iaddr, drq, dack;
  logic [7:0]  idata, odata;
  logic        hrq, omemr_n, omemw_n, oiord_n, oiowr_n, tc, mark, busy;
  logic [15:0] oaddr;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       wr;
    logic [3:0] a;
    logic [7:0] d;
  } reg_vec_t;

  typedef struct {
    logic [15:0] a;
    logic [3:0]  dk;
    logic        t;
    logic        m;
    logic [11:0] strb;
    int          len;
    int          gap;
  } xfer_t;

  xfer_t xq[$];
  xfer_t exq[$];
  reg_vec_t tbl [22];

  k580vt57 dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .iaddr(iaddr), .idata(idata), .odata(odata),
    .iwe_n(iwe_n), .ird_n(ird_n), .drq(drq), .dack(dack), .hrq(hrq), .hlda(hlda),
    .oaddr(oaddr), .omemr_n(omemr_n), .omemw_n(omemw_n), .oiord_n(oiord_n),
    .oiowr_n(oiowr_n), .tc(tc), .mark(mark), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    iaddr = a; idata = d; iwe_n = 1'b0;
    @(negedge clk);
    iwe_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic cpu_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    iaddr = a; ird_n = 1'b0;
    @(negedge clk);
    d = odata;
    ird_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic rd_check(input string name, input logic [3:0] a, input logic [7:0] exp);
    logic [7:0] d;
    cpu_rd(a, d);
    check(name, 32'(d), 32'(exp));
  endtask

  task automatic prog_ch(input logic [1:0] n, input logic [15:0] a, input logic [15:0] cm);
    cpu_wr({1'b0, n, 1'b0}, a[7:0]);
    cpu_wr({1'b0, n, 1'b0}, a[15:8]);
    cpu_wr({1'b0, n, 1'b1}, cm[7:0]);
    cpu_wr({1'b0, n, 1'b1}, cm[15:8]);
  endtask

  function automatic xfer_t mk(input logic [15:0] a, input logic [3:0] dk, input logic t,
                               input logic m, input logic [11:0] strb);
    xfer_t x;
    x.a = a; x.dk = dk; x.t = t; x.m = m; x.strb = strb; x.len = 3; x.gap = 0;
    return x;
  endfunction

  // Holds drq, echoes hlda from hrq, logs each transfer; drq drops at the start of transfer n_stop.
  task automatic dma_run(input logic [3:0] req, input int n_stop, input int budget);
    int started, cyc, ph, last_s1;
    logic [3:0] pdack;
    xfer_t cur;
    xq.delete();
    started = 0; cyc = 0; ph = 0; last_s1 = 0; pdack = '0;
    cur = mk(16'h0, 4'h0, 1'b0, 1'b0, 12'h0);
    @(negedge clk);
    drq = req;
    @(negedge clk);
    check("drq_to_hrq", 32'(hrq), 32'd1);
    hlda = 1'b1;
    @(negedge clk);
    check("hlda_to_dack", 32'(dack != 4'h0), 32'd1);
    while (cyc < budget) begin
      if (dack != 4'h0) begin
        if (pdack == 4'h0) begin
          started++;
          cur = mk(oaddr, dack, tc, mark, 12'h0);
          cur.len = 0;
          cur.gap = (started == 1) ? 0 : cyc - last_s1;
          last_s1 = cyc;
          ph = 0;
          if (started == n_stop) drq = 4'h0;
        end
        if (ph < 3) begin
          cur.strb[9+ph] = ~omemr_n;
          cur.strb[6+ph] = ~omemw_n;
          cur.strb[3+ph] = ~oiord_n;
          cur.strb[ph]   = ~oiowr_n;
        end
        ph++;
        cur.len = ph;
      end else if (pdack != 4'h0) begin
        xq.push_back(cur);
      end
      if (started >= n_stop && dack == 4'h0 && !hrq && !busy) break;
      pdack = dack;
      hlda = hrq;
      @(negedge clk);
      cyc++;
    end
    if (cyc >= budget) check("dma_timeout", 32'd1, 32'd0);
    drq = 4'h0;
    hlda = 1'b0;
  endtask

  task automatic cmp_xfers(input string tag);
    check($sformatf("%s_count", tag), 32'(xq.size()), 32'(exq.size()));
    for (int i = 0; i < exq.size(); i++) begin
      if (i < xq.size()) begin
        check($sformatf("%s[%0d].addr", tag, i), 32'(xq[i].a), 32'(exq[i].a));
        check($sformatf("%s[%0d].dack", tag, i), 32'(xq[i].dk), 32'(exq[i].dk));
        check($sformatf("%s[%0d].tc", tag, i), 32'(xq[i].t), 32'(exq[i].t));
        check($sformatf("%s[%0d].mark", tag, i), 32'(xq[i].m), 32'(exq[i].m));
        check($sformatf("%s[%0d].strobes", tag, i), 32'(xq[i].strb), 32'(exq[i].strb));
        check($sformatf("%s[%0d].len", tag, i), 32'(xq[i].len), 32'd3);
        check($sformatf("%s[%0d].gap", tag, i), 32'(xq[i].gap), (i == 0) ? 32'd0 : 32'd4);
      end
    end
    exq.delete();
  endtask

  task automatic wait_s2(input logic [3:0] req);
    int n;
    @(negedge clk);
    drq = req;
    n = 0;
    do begin @(negedge clk); n++; end while (!hrq && n < 20);
    check("wait_hrq", 32'(hrq), 32'd1);
    hlda = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (dack == 4'h0 && n < 20);
    check("wait_dack", 32'(dack), 32'(req));
    @(negedge clk);
    check("s2_memr", 32'(omemr_n), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    reset_n = 1'b0; ce = 1'b1; iaddr = 4'h0; idata = 8'h00;
    iwe_n = 1'b1; ird_n = 1'b1; drq = 4'h0; hlda = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    check("rst_hrq", 32'(hrq), 32'd0);
    check("rst_dack", 32'(dack), 32'd0);
    check("rst_tc_mark_busy", 32'({tc, mark, busy}), 32'd0);
    check("rst_oaddr", 32'(oaddr), 32'd0);
    check("rst_strobes", 32'({omemr_n, omemw_n, oiord_n, oiowr_n}), 32'hF);
    iaddr = 4'd8;
    #1 check("rst_status", 32'(odata), 32'd0);

    // CPU byte access vectors: wr=1 writes d, wr=0 expects d on read.
    tbl[0]  = '{1'b1, 4'd0, 8'h34};  tbl[1]  = '{1'b1, 4'd0, 8'h12};
    tbl[2]  = '{1'b0, 4'd0, 8'h34};  tbl[3]  = '{1'b0, 4'd0, 8'h12};
    tbl[4]  = '{1'b1, 4'd1, 8'hCD};  tbl[5]  = '{1'b1, 4'd1, 8'h9F};
    tbl[6]  = '{1'b0, 4'd1, 8'hCD};  tbl[7]  = '{1'b0, 4'd1, 8'h9F};
    tbl[8]  = '{1'b1, 4'd2, 8'hAA};  tbl[9]  = '{1'b1, 4'd8, 8'h00};
    tbl[10] = '{1'b1, 4'd2, 8'hBB};  tbl[11] = '{1'b1, 4'd8, 8'h00};
    tbl[12] = '{1'b0, 4'd2, 8'hBB};  tbl[13] = '{1'b0, 4'd2, 8'h00};
    tbl[14] = '{1'b0, 4'd9, 8'h00};  tbl[15] = '{1'b0, 4'd8, 8'h00};
    tbl[16] = '{1'b1, 4'd8, 8'h80};  tbl[17] = '{1'b1, 4'd4, 8'hC3};
    tbl[18] = '{1'b1, 4'd4, 8'h5A};  tbl[19] = '{1'b0, 4'd6, 8'hC3};
    tbl[20] = '{1'b0, 4'd6, 8'h5A};  tbl[21] = '{1'b1, 4'd8, 8'h00};
    for (int i = 0; i < 22; i++) begin
      if (tbl[i].wr) cpu_wr(tbl[i].a, tbl[i].d);
      else rd_check($sformatf("reg_vec%0d", i), tbl[i].a, tbl[i].d);
    end

    // Block transfer on ch2, mem->IO.
    cpu_wr(4'd8, 8'h04);
    prog_ch(2'd2, 16'h76D0, 16'h8003);
    dma_run(4'b0100, 4, 200);
    exq.push_back(mk(16'h76D0, 4'h4, 1'b0, 1'b0, 12'hC04));
    exq.push_back(mk(16'h76D1, 4'h4, 1'b0, 1'b0, 12'hC04));
    exq.push_back(mk(16'h76D2, 4'h4, 1'b0, 1'b0, 12'hC04));
    exq.push_back(mk(16'h76D3, 4'h4, 1'b1, 1'b1, 12'hC04));
    cmp_xfers("blk");
    rd_check("blk_status", 4'd8, 8'h04);
    rd_check("blk_status_clr", 4'd8, 8'h00);

    // Autoload: ch2 reloads from ch3 after its terminal count.
    cpu_wr(4'd8, 8'hA4);
    prog_ch(2'd2, 16'h76D0, 16'h8001);
    dma_run(4'b0100, 3, 200);
    exq.push_back(mk(16'h76D0, 4'h4, 1'b0, 1'b0, 12'hC06));
    exq.push_back(mk(16'h76D1, 4'h4, 1'b1, 1'b1, 12'hC06));
    exq.push_back(mk(16'h76D0, 4'h4, 1'b0, 1'b0, 12'hC06));
    cmp_xfers("auto");
    rd_check("auto_status", 4'd8, 8'h14);
    rd_check("auto_status_clr", 4'd8, 8'h00);

    // Fixed priority with TC stop: ch0 block, then ch1 block.
    cpu_wr(4'd8, 8'h43);
    prog_ch(2'd0, 16'h1000, 16'h8001);
    prog_ch(2'd1, 16'h2000, 16'h8001);
    dma_run(4'b0011, 4, 200);
    exq.push_back(mk(16'h1000, 4'h1, 1'b0, 1'b0, 12'hC04));
    exq.push_back(mk(16'h1001, 4'h1, 1'b1, 1'b1, 12'hC04));
    exq.push_back(mk(16'h2000, 4'h2, 1'b0, 1'b0, 12'hC04));
    exq.push_back(mk(16'h2001, 4'h2, 1'b1, 1'b1, 12'hC04));
    cmp_xfers("fixed");

    // Rotating priority: channels alternate.
    cpu_wr(4'd8, 8'h53);
    prog_ch(2'd0, 16'h1000, 16'h8001);
    prog_ch(2'd1, 16'h2000, 16'h8001);
    dma_run(4'b0011, 4, 200);
    exq.push_back(mk(16'h1000, 4'h1, 1'b0, 1'b0, 12'hC04));
    exq.push_back(mk(16'h2000, 4'h2, 1'b0, 1'b0, 12'hC04));
    exq.push_back(mk(16'h1001, 4'h1, 1'b1, 1'b1, 12'hC04));
    exq.push_back(mk(16'h2001, 4'h2, 1'b1, 1'b1, 12'hC04));
    cmp_xfers("rot");

    // Write mode on ch1 with and without extended write.
    cpu_wr(4'd8, 8'h22);
    prog_ch(2'd1, 16'h3000, 16'h4000);
    dma_run(4'b0010, 1, 100);
    exq.push_back(mk(16'h3000, 4'h2, 1'b1, 1'b1, 12'h1B0));
    cmp_xfers("extw");
    cpu_wr(4'd8, 8'h02);
    prog_ch(2'd1, 16'h3000, 16'h4000);
    dma_run(4'b0010, 1, 100);
    exq.push_back(mk(16'h3000, 4'h2, 1'b1, 1'b1, 12'h130));
    cmp_xfers("normw");

    // hlda dropped in S2: cycle completes, then idle.
    cpu_wr(4'd8, 8'h01);
    prog_ch(2'd0, 16'h5000, 16'h8005);
    wait_s2(4'b0001);
    hlda = 1'b0;
    drq = 4'h0;
    @(negedge clk);
    check("hdrop_s3_memr", 32'(omemr_n), 32'd0);
    @(negedge clk);
    check("hdrop_s4", 32'({hrq, dack}), 32'h10);
    @(negedge clk);
    check("hdrop_hrq", 32'(hrq), 32'd0);
    check("hdrop_busy", 32'(busy), 32'd0);
    rd_check("hdrop_addr_lo", 4'd0, 8'h01);
    rd_check("hdrop_addr_hi", 4'd0, 8'h50);
    rd_check("hdrop_cnt_lo", 4'd1, 8'h04);
    rd_check("hdrop_cnt_hi", 4'd1, 8'h80);

    // Asynchronous reset in S2.
    wait_s2(4'b0001);
    reset_n = 1'b0;
    #1;
    check("arst_strobes", 32'({omemr_n, omemw_n, oiord_n, oiowr_n}), 32'hF);
    check("arst_dack_hrq", 32'({hrq, dack}), 32'h0);
    check("arst_busy", 32'(busy), 32'd0);
    drq = 4'h0;
    hlda = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rd_check("arst_addr", 4'd0, 8'h00);
    rd_check("arst_status", 4'd8, 8'h00);

    d = 8'h00;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
